// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key decoder.
// Prefix codes, discard list and ps2_key field positions.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  localparam int N_DISCARD = 6;
  localparam logic [7:0] DISCARD_CODES [N_DISCARD] = '{
    8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF
  };

  localparam int KEY_TOGGLE  = 10;
  localparam int KEY_PRESSED = 9;
  localparam int KEY_EXT     = 8;

  function automatic logic is_discard(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_DISCARD; i++) begin
      if (b == DISCARD_CODES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Decoded key event bus from the PS/2 receiver
// to the scancode-to-matrix consumer.
interface ps2_key_if;
  logic [10:0] ps2_key;
  logic        frame_err;
  logic        busy;

  modport master (
    output ps2_key,
    output frame_err,
    output busy
  );

  modport slave (
    input ps2_key,
    input frame_err,
    input busy
  );
endinterface

// File: rtl/ps2_line_filter.sv
// Synchronizes the PS/2 lines, debounces ps2_clk and
// strobes one cycle on each filtered falling edge.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data_sync
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          filt;
  logic [CW-1:0] cnt;

  assign data_sync = dat_sync[1];

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt     <= 1'b1;
      cnt      <= '0;
      fall     <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      fall     <= 1'b0;
      if (clk_sync[1] == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        // FILTER_LEN differing samples in a row: accept new level
        filt <= clk_sync[1];
        cnt  <= '0;
        fall <= filt;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Host-side PS/2 receiver: frames bytes, tracks E0/F0/E1
// prefixes and emits toggle-strobed make/break events.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  ps2_key_if.master  key_if
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          fall;
  logic          data;
  ps2_state_e    state_q, state_d;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] to_cnt;
  logic          ext_q, rel_q;
  logic [2:0]    skip_q;
  logic [10:0]   key_q;
  logic          err_q;
  logic          timeout;
  logic          frame_done;
  logic          frame_ok;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .fall      (fall),
    .data_sync (data)
  );

  assign timeout  = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign frame_ok = ((^shift_q) ^ par_q) & data;

  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    unique case (state_q)
      IDLE:   if (fall && !data) state_d = DATA;
      DATA:   if (fall && bit_cnt == 3'd7) state_d = PARITY;
      PARITY: if (fall) state_d = STOP;
      STOP: begin
        if (fall) begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // a bit arriving in the expiry cycle takes priority
    if (!fall && timeout && state_q != IDLE) state_d = IDLE;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      to_cnt  <= '0;
      ext_q   <= 1'b0;
      rel_q   <= 1'b0;
      skip_q  <= '0;
      key_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (fall || state_d == IDLE) to_cnt <= '0;
      else                         to_cnt <= to_cnt + 1'b1;

      if (fall) begin
        unique case (state_q)
          IDLE: bit_cnt <= '0;
          DATA: begin
            shift_q <= {data, shift_q[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: par_q <= data;
          default: ;
        endcase
      end

      if (frame_done && !frame_ok) begin
        err_q <= 1'b1;
        ext_q <= 1'b0;
        rel_q <= 1'b0;
      end else if (frame_done) begin
        if (skip_q != 3'd0) begin
          skip_q <= skip_q - 3'd1;
        end else if (shift_q == PS2_PAUSE) begin
          skip_q <= PAUSE_SKIP;
        end else if (shift_q == PS2_EXT) begin
          ext_q <= 1'b1;
        end else if (shift_q == PS2_BRK) begin
          rel_q <= 1'b1;
        end else if (is_discard(shift_q) && !ext_q && !rel_q) begin
          key_q <= key_q;
        end else begin
          key_q[KEY_TOGGLE]  <= ~key_q[KEY_TOGGLE];
          key_q[KEY_PRESSED] <= ~rel_q;
          key_q[KEY_EXT]     <= ext_q;
          key_q[7:0]         <= shift_q;
          ext_q <= 1'b0;
          rel_q <= 1'b0;
        end
      end
    end
  end

  assign key_if.ps2_key   = key_q;
  assign key_if.frame_err = err_q;
  assign key_if.busy      = (state_q != IDLE);

endmodule
